// File: rtl/id_regfile_mp_if.sv
// Decode/WB-side bundle of the dual-issue ID register file: read ports, write-back ports,
// issue tracking and flush.
interface id_regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] Read_Address_ID;
    logic [NUM_RD*DATA_W-1:0] Read_Data_ID;
    logic [NUM_RD-1:0]        Read_Busy_ID;

    logic                     RegWrite0_WB;
    logic [ADDR_W-1:0]        Write_Register0_WB;
    logic [DATA_W-1:0]        Write_Data0_WB;
    logic                     RegWrite1_WB;
    logic [ADDR_W-1:0]        Write_Register1_WB;
    logic [DATA_W-1:0]        Write_Data1_WB;

    logic                     Issue_Valid_ID;
    logic [ADDR_W-1:0]        Issue_Register_ID;
    logic                     Flush;

    modport master (
        output Read_Address_ID,
        input  Read_Data_ID,
        input  Read_Busy_ID,
        output RegWrite0_WB, Write_Register0_WB, Write_Data0_WB,
        output RegWrite1_WB, Write_Register1_WB, Write_Data1_WB,
        output Issue_Valid_ID, Issue_Register_ID, Flush
    );

    modport slave (
        input  Read_Address_ID,
        output Read_Data_ID,
        output Read_Busy_ID,
        input  RegWrite0_WB, Write_Register0_WB, Write_Data0_WB,
        input  RegWrite1_WB, Write_Register1_WB, Write_Data1_WB,
        input  Issue_Valid_ID, Issue_Register_ID, Flush
    );
endinterface

// File: rtl/id_regfile_mp.sv
// Multi-read, dual write-back ID register file with a pending-write scoreboard.
// Define ID_REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module id_regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input logic            Clk,
    input logic            Rst_n,
    id_regfile_mp_if.slave rf
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;

    logic wr0_c;
    logic wr1_c;
    logic iss_c;

    assign wr0_c = rf.RegWrite0_WB   && (rf.Write_Register0_WB != ADDR_W'(0));
    assign wr1_c = rf.RegWrite1_WB   && (rf.Write_Register1_WB != ADDR_W'(0));
    assign iss_c = rf.Issue_Valid_ID && (rf.Issue_Register_ID  != ADDR_W'(0));

    // Register array; port 1 is applied last so it wins an address collision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_c) regs[rf.Write_Register0_WB] <= rf.Write_Data0_WB;
            if (wr1_c) regs[rf.Write_Register1_WB] <= rf.Write_Data1_WB;
        end
    end

    // Scoreboard: write-back clears, a newer issue re-sets, flush drops everything.
    always_comb begin
        pending_next = pending;
        if (wr0_c) pending_next[rf.Write_Register0_WB] = 1'b0;
        if (wr1_c) pending_next[rf.Write_Register1_WB] = 1'b0;
        if (iss_c) pending_next[rf.Issue_Register_ID]  = 1'b1;
        if (rf.Flush) pending_next = '0;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] addr_c;
        logic [DATA_W-1:0] data_c;
        logic              busy_c;

        assign addr_c = rf.Read_Address_ID[k*ADDR_W +: ADDR_W];

        always_comb begin
            data_c = regs[addr_c];
            busy_c = pending[addr_c];
`ifdef ID_REGFILE_BYPASS_EN
            if (wr0_c && (rf.Write_Register0_WB == addr_c)) begin
                data_c = rf.Write_Data0_WB;
                busy_c = 1'b0;
            end
            if (wr1_c && (rf.Write_Register1_WB == addr_c)) begin
                data_c = rf.Write_Data1_WB;
                busy_c = 1'b0;
            end
`endif
            if (addr_c == ADDR_W'(0)) begin
                data_c = '0;
                busy_c = 1'b0;
            end
        end

        assign rf.Read_Data_ID[k*DATA_W +: DATA_W] = data_c;
        assign rf.Read_Busy_ID[k]                  = busy_c;
    end
endmodule
